// File: rtl/data_bus_timer_if.sv
// data_bus_timer_if: CPU data-memory bus between the master and a memory-mapped responder
interface data_bus_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_bus_timer.sv
// data_bus_timer: memory-mapped prescaled countdown timer with one-shot/auto-reload and level irq
module data_bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter bit          REG_OUT   = 1'b0,
  parameter int          PRE_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  data_bus_timer_if.slave  bus,
  output logic             irq_o
);
  logic [2:0]       ctrl;
  logic             expired;
  logic [31:0]      load, count, load_m, rdata;
  logic [PRE_W-1:0] prescale, pcnt, pre_m;
  logic [5:0]       widx;
  logic             hit, wr, rd, wr_ctrl, wr_stat, wr_load, wr_pre, tick, expire;
  logic             unused;
  assign unused  = ^bus.addr[1:0];
  assign widx    = bus.addr[7:2];
  assign hit     = bus.addr[31:8] == BASE_ADDR[31:8];
  assign wr      = bus.ce & bus.we & hit;
  assign rd      = bus.ce & ~bus.we & hit;
  assign wr_ctrl = wr && widx == 6'd0;
  assign wr_stat = wr && widx == 6'd1;
  assign wr_load = wr && widx == 6'd2;
  assign wr_pre  = wr && widx == 6'd4;
  assign tick    = ctrl[0] && pcnt == prescale;
  // a LOAD write on a tick edge takes precedence over every tick effect
  assign expire  = tick & ~wr_load & (count == 32'd0);
  assign irq_o   = expired & ctrl[2];
  always_comb begin
    load_m = load;
    pre_m  = prescale;
    for (int i = 0; i < 32; i++) load_m[i] = bus.sel[i/8] ? bus.data_i[i] : load[i];
    for (int i = 0; i < PRE_W; i++) pre_m[i] = bus.sel[i/8] ? bus.data_i[i] : prescale[i];
  end
  always_comb begin
    rdata = widx == 6'd0 ? {29'd0, ctrl} :
            widx == 6'd1 ? {31'd0, expired} :
            widx == 6'd2 ? load :
            widx == 6'd3 ? count :
            widx == 6'd4 ? 32'(prescale) : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      expired  <= 1'b0;
      load     <= '0;
      count    <= '0;
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      ctrl     <= wr_ctrl ? (bus.sel[0] ? bus.data_i[2:0] : ctrl) :
                  (expire & ~ctrl[1]) ? {ctrl[2:1], 1'b0} : ctrl;
      expired  <= expire | (expired & ~(wr_stat & bus.sel[0] & bus.data_i[0]));
      load     <= wr_load ? load_m : load;
      prescale <= wr_pre ? pre_m : prescale;
      count    <= wr_load ? load_m :
                  !tick ? count :
                  count != 32'd0 ? count - 32'd1 :
                  ctrl[1] ? load : count;
      pcnt     <= (wr_load | ~ctrl[0] | tick) ? '0 : pcnt + PRE_W'(1);
    end
  end
  generate
    if (REG_OUT) begin : g_reg
      logic [31:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else if (rd) data_q <= rdata;
      end
      assign bus.data_o = data_q;
    end else begin : g_comb
      assign bus.data_o = rd ? rdata : 32'd0;
    end
  endgenerate
endmodule

// File: doc/data_bus_timer.md
Name: data_bus_timer

Overview:
- Memory-mapped countdown timer that acts as a responder on the CPU data-memory bus (ce/we/addr/sel/data_i/data_o).
- Sits beside the data RAM at the SOPC top level. The top-level decoder steers the bus to this block by address window.
- Provides prescaled decrement, one-shot or auto-reload operation, a sticky expiry flag, and a level interrupt to the CPU.

Parameters:
- BASE_ADDR, 32'h2000_0000, block window base; decode matches addr[31:8] == BASE_ADDR[31:8].
- REG_OUT, 0, read latency: 0 = combinational data_o, 1 = data_o registered (one-cycle read latency).
- PRE_W, 16, prescaler width in bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  bus access enable (chip enable from CPU)
- we  input  1  1 = write, 0 = read; valid while ce=1
- addr  input  32  byte address; addr[1:0] ignored
- sel  input  4  byte lane enables for writes; sel[3] = data_i[31:24]
- data_i  input  32  write data from CPU
- data_o  output  32  read data to CPU
- irq_o  output  1  level interrupt, = STATUS.expired & CTRL.irq_en

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 clears all registers immediately. Reset values: CTRL=0, STATUS=0, LOAD=0, COUNT=0, PRESCALE=0, prescale counter=0, data_o=0, irq_o=0. If reset asserts mid-count, the count is lost; the timer resumes only after software re-enables it.
- Register map (offset = addr[7:0]):
  - 0x00 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 STATUS: bit0 expired; write-1-to-clear.
  - 0x08 LOAD: 32-bit reload value.
  - 0x0C COUNT: read-only; writes ignored.
  - 0x10 PRESCALE: [PRE_W-1:0]; upper bits read 0.
  - All other offsets read 0; writes to them are ignored.
- A write is accepted on a rising edge with ce=1, we=1 and the address decode hit. Only lanes with sel[n]=1 update. The new value is visible from the next cycle.
- A write to LOAD also copies the merged (byte-masked) LOAD value into COUNT on the same edge and clears the prescale counter.
- Read:
  - REG_OUT=0: data_o = selected register whenever ce=1, we=0 and decode hits; otherwise 0.
  - REG_OUT=1: the same value is captured on the edge; data_o holds until the next read access and is 0 after reset.
- Prescaler: while en=1, pcnt increments each cycle. When pcnt == PRESCALE, a tick fires and pcnt returns to 0. PRESCALE=0 therefore gives a tick every cycle. While en=0, pcnt is held at 0.
- On a tick:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: expired is set. If auto_reload=1, COUNT <= LOAD. Otherwise COUNT stays 0 and hardware clears en.
- Expiry period with auto-reload = (LOAD+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - STATUS W1C in the same cycle as a hardware expiry: expired ends at 1 (set wins).
  - A CTRL write in the same cycle as a hardware en-clear: the written value wins.
  - A LOAD write in the same cycle as a tick: the LOAD write wins; no decrement is applied.
- COUNT wraps never. Decrement stops at 0, with no underflow to 0xFFFF_FFFF.
- irq_o is driven from flops only, with no combinational path from bus inputs.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle. Required: irq_o=0, data_o=0, and all registers read 0 after release.
- One-shot:
  - Stimulus: PRESCALE=0, write LOAD=3, then CTRL=0x5.
  - Required: COUNT reads 3,2,1,0 on successive cycles; expired=1 and irq_o=1 on the next tick; en reads 0.
  - Then write STATUS=0x1. Required: irq_o drops the following cycle.
- Auto-reload with prescale:
  - Stimulus: PRESCALE=2, LOAD=1, CTRL=0x7.
  - Required: expiry every 6 cycles, COUNT cycles 1,0,1,0.
  - W1C issued on the exact expiry cycle: expired remains 1.
- Byte lanes: write 0xAABBCCDD to LOAD with sel=4'b0101. Required: LOAD reads 0x00BB00DD and COUNT reads 0x00BB00DD.
- Decode and read latency:
  - Read 0x2000_0014, or any address with addr[31:8] != 0x200000. Required: data_o=0, and writes to those addresses change no state.
  - With REG_OUT=1, a read of CTRL appears on data_o one cycle after the access.
- Collision: a LOAD write (0x10) on the same edge as a tick. Required: COUNT=0x10 the next cycle, not 0x0F.
